// File: rtl/pipe_hazard_chain.sv
// In-order record chain behind decode: carries per-instruction results to writeback,
// and picks forwarding sources / load-use stalls for the two decode read ports.
module pipe_hazard_chain #(
  parameter int STAGES = 3,
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int TNEW_W = 2,
  parameter int EXC_W  = 5,
  localparam int SEL_W = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [AW-1:0]            in_wa,
  input  logic                     in_we,
  input  logic [TNEW_W-1:0]        in_tnew,
  input  logic [EXC_W-1:0]         in_exc,
  input  logic                     in_bd,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [STAGES-1:0]        upd_en,
  input  logic [STAGES*DATA_W-1:0] upd_data,
  input  logic [AW-1:0]            rd_a1,
  input  logic [AW-1:0]            rd_a2,
  input  logic [TNEW_W-1:0]        tuse1,
  input  logic [TNEW_W-1:0]        tuse2,
  output logic                     stall_req,
  output logic [SEL_W-1:0]         fwd_sel1,
  output logic [SEL_W-1:0]         fwd_sel2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic                     out_valid,
  output logic                     out_we,
  output logic [AW-1:0]            out_wa,
  output logic [DATA_W-1:0]        out_data,
  output logic [EXC_W-1:0]         out_exc,
  output logic                     out_bd
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     wa;
    logic              we;
    logic [TNEW_W-1:0] tnew;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } rec_t;

  rec_t              stg_q [STAGES];
  rec_t              stg_d [STAGES];
  logic [DATA_W-1:0] cur_data [STAGES];
  logic [STAGES-1:0] eff_we;

  // A stage's "current" value already includes a result produced this cycle.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      cur_data[k] = upd_en[k] ? upd_data[k*DATA_W +: DATA_W] : stg_q[k].data;
      eff_we[k]   = stg_q[k].valid & stg_q[k].we & (stg_q[k].wa != '0);
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k] = '0;
    end
    if (in_valid && !stall) begin
      stg_d[0].valid = 1'b1;
      stg_d[0].data  = in_data;
      stg_d[0].wa    = in_wa;
      stg_d[0].we    = in_we;
      stg_d[0].tnew  = in_tnew;
      stg_d[0].exc   = in_exc;
      stg_d[0].bd    = in_bd;
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      stg_d[k+1]      = stg_q[k];
      stg_d[k+1].data = cur_data[k];
      stg_d[k+1].tnew = (stg_q[k].tnew == '0) ? '0 : stg_q[k].tnew - TNEW_W'(1);
    end
    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  logic [AW-1:0]     rd_a    [2];
  logic [TNEW_W-1:0] tuse    [2];
  logic              hz_stall[2];
  logic [SEL_W-1:0]  hz_sel  [2];
  logic [DATA_W-1:0] hz_data [2];

  assign rd_a[0] = rd_a1;
  assign rd_a[1] = rd_a2;
  assign tuse[0] = tuse1;
  assign tuse[1] = tuse2;

  // Youngest matching writer is the producer; once found, older stages are ignored.
  always_comb begin
    logic found;
    found = 1'b0;
    for (int p = 0; p < 2; p++) begin
      hz_stall[p] = 1'b0;
      hz_sel[p]   = '0;
      hz_data[p]  = '0;
      found       = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!found && (rd_a[p] != '0) && eff_we[k] && (stg_q[k].wa == rd_a[p])) begin
          found = 1'b1;
          if ((stg_q[k].tnew == '0) || upd_en[k]) begin
            hz_sel[p]  = SEL_W'(k + 1);
            hz_data[p] = cur_data[k];
          end else if (stg_q[k].tnew > tuse[p]) begin
            hz_stall[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_req = hz_stall[0] | hz_stall[1];
  assign fwd_sel1  = hz_sel[0];
  assign fwd_sel2  = hz_sel[1];
  assign fwd_data1 = hz_data[0];
  assign fwd_data2 = hz_data[1];

  assign out_valid = stg_q[STAGES-1].valid;
  assign out_we    = eff_we[STAGES-1];
  assign out_wa    = stg_q[STAGES-1].wa;
  assign out_data  = stg_q[STAGES-1].data;
  assign out_exc   = stg_q[STAGES-1].exc;
  assign out_bd    = stg_q[STAGES-1].bd;

endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Directed bench for pipe_hazard_chain: scoreboard of expected oldest-stage records
// plus point checks of the combinational hazard/forwarding outputs.
module tb_pipe_hazard_chain;
  localparam int S  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam int EW = 5;
  localparam int SW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_wa;
  logic          in_we;
  logic [TW-1:0] in_tnew;
  logic [EW-1:0] in_exc;
  logic          in_bd;
  logic          stall;
  logic          flush;
  logic [S-1:0]  upd_en;
  logic [S*DW-1:0] upd_data;
  logic [AW-1:0] rd_a1, rd_a2;
  logic [TW-1:0] tuse1, tuse2;
  logic          stall_req;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic          out_valid, out_we, out_bd;
  logic [AW-1:0] out_wa;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exc;

  pipe_hazard_chain #(.STAGES(S), .DATA_W(DW), .AW(AW), .TNEW_W(TW), .EXC_W(EW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_wa(in_wa), .in_we(in_we),
    .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .stall(stall), .flush(flush), .upd_en(upd_en), .upd_data(upd_data),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .tuse1(tuse1), .tuse2(tuse2),
    .stall_req(stall_req), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .out_valid(out_valid), .out_we(out_we), .out_wa(out_wa), .out_data(out_data),
    .out_exc(out_exc), .out_bd(out_bd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] data;
    logic [EW-1:0] exc;
    logic          bd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_wa = '0; in_we = 1'b0; in_tnew = '0;
    in_exc = '0; in_bd = 1'b0; stall = 1'b0; flush = 1'b0;
    upd_en = '0; upd_data = '0;
  endtask

  task automatic set_rec(input logic [DW-1:0] d, input logic [AW-1:0] wa,
                         input logic we, input logic [TW-1:0] tn,
                         input logic [EW-1:0] exc, input logic bd);
    in_valid = 1'b1; in_data = d; in_wa = wa; in_we = we; in_tnew = tn;
    in_exc = exc; in_bd = bd;
  endtask

  // Queue holds stage contents oldest-first below the output stage: exp_q[S-2-k] is stage k.
  task automatic cycle(input string tag);
    exp_t e;
    if (flush) begin
      foreach (exp_q[i]) exp_q[i] = '0;
    end else begin
      for (int k = 0; k < S - 1; k++)
        if (upd_en[k]) exp_q[S-2-k].data = upd_data[k*DW +: DW];
    end
    e = '0;
    if (in_valid && !stall && !flush) begin
      e.valid = 1'b1;
      e.we    = in_we && (in_wa != '0);
      e.wa    = in_wa;
      e.data  = in_data;
      e.exc   = in_exc;
      e.bd    = in_bd;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, 64'({out_valid, out_we, out_wa, out_data, out_exc, out_bd}), 64'(e));
  endtask

  task automatic reset_queue();
    exp_q.delete();
    for (int i = 0; i < S - 1; i++) exp_q.push_back('0);
  endtask

  initial begin
    idle_inputs();
    rd_a1 = '0; rd_a2 = '0; tuse1 = '0; tuse2 = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_all", 64'({out_we, out_wa, out_data, out_exc, out_bd}), 64'd0);
    chk("rst_hazard", 64'({stall_req, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2}), 64'd0);
    reset = 1'b1;
    reset_queue();

    // single record travels to the oldest stage
    set_rec(32'h1234, 5'd8, 1'b1, 2'd0, 5'd0, 1'b0);
    cycle("single_inj");
    idle_inputs();
    repeat (4) cycle("single_drain");

    // load-use: producer tnew=2, consumer tuse=0
    set_rec(32'h3333, 5'd3, 1'b1, 2'd2, 5'd0, 1'b0);
    cycle("lu_inj");
    idle_inputs();
    rd_a1 = 5'd3; tuse1 = 2'd0;
    #1;
    chk("lu_stall_t2", 64'(stall_req), 64'd1);
    chk("lu_sel_t2", 64'(fwd_sel1), 64'd0);
    stall = stall_req;
    set_rec(32'hDEAD, 5'd9, 1'b1, 2'd0, 5'd0, 1'b0);
    cycle("lu_bubble1");
    #1;
    chk("lu_stall_t1", 64'(stall_req), 64'd1);
    rd_a1 = 5'd0; rd_a2 = 5'd3; tuse2 = 2'd1;
    #1;
    chk("lu_late_fwd_nostall", 64'(stall_req), 64'd0);
    chk("lu_late_fwd_sel", 64'({fwd_sel2, fwd_data2}), 64'd0);
    rd_a1 = 5'd3; rd_a2 = 5'd0; tuse2 = 2'd0;
    #1;
    stall = stall_req;
    cycle("lu_bubble2");
    stall = 1'b0;
    idle_inputs();
    #1;
    chk("lu_stall_t0", 64'(stall_req), 64'd0);
    chk("lu_sel_t0", 64'(fwd_sel1), 64'd3);
    chk("lu_data_t0", 64'(fwd_data1), 64'h3333);
    rd_a1 = '0;
    repeat (2) cycle("lu_drain");

    // youngest match wins
    set_rec(32'hB, 5'd5, 1'b1, 2'd0, 5'd1, 1'b1);
    cycle("yw_old");
    set_rec(32'hA, 5'd5, 1'b1, 2'd0, 5'd2, 1'b0);
    cycle("yw_young");
    idle_inputs();
    rd_a2 = 5'd5; tuse2 = 2'd0;
    #1;
    chk("yw_sel2", 64'(fwd_sel2), 64'd1);
    chk("yw_data2", 64'(fwd_data2), 64'hA);
    chk("yw_stall", 64'(stall_req), 64'd0);
    rd_a2 = '0;
    repeat (3) cycle("yw_drain");

    // writes to register 0 never forward and never commit
    set_rec(32'hFFFF, 5'd0, 1'b1, 2'd3, 5'd0, 1'b0);
    cycle("z_inj");
    idle_inputs();
    rd_a1 = 5'd0; rd_a2 = 5'd0; tuse1 = 2'd0;
    #1;
    chk("z_sel1", 64'(fwd_sel1), 64'd0);
    chk("z_stall", 64'(stall_req), 64'd0);
    repeat (3) cycle("z_drain");

    // in-flight result via upd_en
    set_rec(32'h1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0);
    cycle("upd_inj");
    idle_inputs();
    cycle("upd_adv");
    upd_en = 3'b010;
    upd_data = '0;
    upd_data[1*DW +: DW] = 32'h55;
    rd_a1 = 5'd7; tuse1 = 2'd0;
    #1;
    chk("upd_sel1", 64'(fwd_sel1), 64'd2);
    chk("upd_data1", 64'(fwd_data1), 64'h55);
    chk("upd_stall", 64'(stall_req), 64'd0);
    cycle("upd_commit");
    upd_en = '0; upd_data = '0;
    #1;
    chk("upd_stage2_sel", 64'(fwd_sel1), 64'd3);
    chk("upd_stage2_data", 64'(fwd_data1), 64'h55);
    rd_a1 = '0;
    cycle("upd_drain");

    // flush beats stall and upd_en with a full chain
    set_rec(32'h11, 5'd1, 1'b1, 2'd3, 5'd4, 1'b1);
    cycle("fl_fill0");
    set_rec(32'h22, 5'd2, 1'b1, 2'd3, 5'd5, 1'b0);
    cycle("fl_fill1");
    set_rec(32'h33, 5'd3, 1'b1, 2'd3, 5'd6, 1'b1);
    cycle("fl_fill2");
    set_rec(32'h44, 5'd4, 1'b1, 2'd0, 5'd7, 1'b0);
    stall = 1'b1; flush = 1'b1; upd_en = '1; upd_data = {3{32'hCAFE}};
    cycle("fl_edge");
    idle_inputs();
    rd_a1 = 5'd2; rd_a2 = 5'd1; tuse1 = 2'd0; tuse2 = 2'd0;
    #1;
    chk("fl_hazard_clear", 64'({stall_req, fwd_sel1, fwd_sel2}), 64'd0);
    chk("fl_exc", 64'(out_exc), 64'd0);
    rd_a1 = '0; rd_a2 = '0;
    repeat (S - 1) cycle("fl_after");

    // asynchronous reset mid-operation
    set_rec(32'h77, 5'd6, 1'b1, 2'd0, 5'd3, 1'b1);
    cycle("ar_inj");
    idle_inputs();
    repeat (S - 1) cycle("ar_adv");
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out_all", 64'({out_we, out_wa, out_data, out_exc, out_bd}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    reset_queue();
    repeat (2) cycle("ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
